// File: rtl/par_tx_buf_if.sv
// par_tx_buf_if -- bundles the producer-side and link-side signals of par_tx_buf.
//
// Signals:
//   req          producer offers parallel_in this cycle
//   parallel_in  flit from the router core (WIDTH bits)
//   tx_busy      buffer full; req is ignored while high
//   channel_busy link cannot take a flit this cycle
//   item_out     flit presented to the link (registered)
//   valid        item_out holds a flit (registered)
//
// Modports:
//   slave  - the transmitter buffer itself
//   master - the environment around it (router core + link)
interface par_tx_buf_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic [WIDTH-1:0] parallel_in;
  logic             tx_busy;
  logic             channel_busy;
  logic [WIDTH-1:0] item_out;
  logic             valid;

  modport master (
    output req, parallel_in, channel_busy,
    input  tx_busy, item_out, valid
  );

  modport slave (
    input  req, parallel_in, channel_busy,
    output tx_busy, item_out, valid
  );
endinterface

// File: rtl/par_tx_buf.sv
// par_tx_buf -- buffered parallel flit transmitter for a router output port.
//
// Flits accepted from the router core are held in a DEPTH-entry circular FIFO
// followed by a registered output stage (item_out/valid). Total capacity is
// DEPTH+1 flits. The output stage holds its flit until the link is not busy.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-low reset
//   bus        par_tx_buf_if.slave (req, parallel_in, tx_busy,
//              channel_busy, item_out, valid)
//   level      flits held, including the output register (0..DEPTH+1)
//   stall_cnt  saturating count of cycles with valid && channel_busy
//              (present only when PAR_TX_STALL_CNT_EN is defined)
//
// Optional feature macro: PAR_TX_STALL_CNT_EN
//
// Handshake semantics:
//   producer side: a flit is accepted at an edge iff req && !tx_busy.
//                  tx_busy depends only on registered state, so a pop in the
//                  same cycle never unblocks a push.
//   link side:     a flit is consumed at an edge iff valid && !channel_busy.
//                  While valid && channel_busy, item_out and valid are stable.
module par_tx_buf #(
  parameter int    WIDTH   = 32,
  parameter int    DEPTH   = 4,
  parameter int    LVL_W   = 3,
  parameter int    STALL_W = 16,
  parameter string port    = "unknown"
) (
  input  logic             clk,
  input  logic             reset,
  par_tx_buf_if.slave      bus,
`ifdef PAR_TX_STALL_CNT_EN
  output logic [STALL_W-1:0] stall_cnt,
`endif
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [WIDTH-1:0] item_q,   item_d;
  logic             valid_q,  valid_d;
  logic [LVL_W-1:0] level_q,  level_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  logic             push;
  logic             pop;
  logic             out_free;
  logic             fifo_wr;
  logic [LVL_W-1:0] fifo_cnt;

  assign bus.tx_busy  = (level_q == FULL_LVL);
  assign bus.item_out = item_q;
  assign bus.valid    = valid_q;
  assign level        = level_q;

  // The output register is always filled first, so the FIFO holds
  // everything beyond the one flit that sits in item_q.
  assign fifo_cnt = level_q - LVL_W'(valid_q);

  always_comb begin
    push     = bus.req && !bus.tx_busy;
    pop      = valid_q && !bus.channel_busy;
    out_free = !valid_q || pop;

    item_d   = item_q;
    valid_d  = valid_q && !pop;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    fifo_wr  = 1'b0;

    if (out_free && fifo_cnt != '0) begin
      // Refill from the FIFO head; a simultaneous push still queues behind.
      item_d   = mem_q[rd_ptr_q];
      valid_d  = 1'b1;
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      fifo_wr  = push;
    end else if (out_free && push) begin
      // Bypass: empty FIFO and free output stage, flit goes straight out.
      item_d  = bus.parallel_in;
      valid_d = 1'b1;
    end else begin
      fifo_wr = push;
    end

    if (fifo_wr) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      item_q   <= '0;
      valid_q  <= 1'b0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      item_q   <= item_d;
      valid_q  <= valid_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array carries data only; pointers and level define validity,
  // so it needs no reset.
  always_ff @(posedge clk) begin
    if (reset && fifo_wr) begin
      mem_q[wr_ptr_q] <= bus.parallel_in;
    end
  end

`ifdef PAR_TX_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (valid_q && bus.channel_busy && stall_q != {STALL_W{1'b1}}) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_par_tx_buf.sv
// tb_par_tx_buf -- self-checking bench for par_tx_buf.
//
// Reference model: the buffer is a FIFO of up to DEPTH+1 flits whose oldest
// entry is what the link sees. valid == (held > 0), item_out == oldest,
// tx_busy == (held == DEPTH+1), level == held.
module tb_par_tx_buf;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int LVL_W   = 3;
  localparam int STALL_W = 4;
  localparam int CAP     = DEPTH + 1;

  logic clk;
  logic reset;
  logic [LVL_W-1:0] level;
`ifdef PAR_TX_STALL_CNT_EN
  logic [STALL_W-1:0] stall_cnt;
`endif

  par_tx_buf_if #(.WIDTH(WIDTH)) bus ();

  par_tx_buf #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .LVL_W(LVL_W), .STALL_W(STALL_W),
    .port("tb")
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
`ifdef PAR_TX_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .level(level)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [WIDTH-1:0] exp_q[$];
  int vectors = 0;
  int errors  = 0;
  int exp_stall = 0;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"},   WIDTH'(bus.valid),   WIDTH'(exp_q.size() > 0));
    chk({tag, ".level"},   WIDTH'(level),       WIDTH'(exp_q.size()));
    chk({tag, ".tx_busy"}, WIDTH'(bus.tx_busy), WIDTH'(exp_q.size() == CAP));
    if (exp_q.size() > 0) chk({tag, ".item_out"}, bus.item_out, exp_q[0]);
`ifdef PAR_TX_STALL_CNT_EN
    chk({tag, ".stall_cnt"}, WIDTH'(stall_cnt), WIDTH'(exp_stall));
`endif
  endtask

  // One clock cycle: drive inputs, advance the model, check after the edge.
  task automatic cycle(input string tag, input logic r,
                       input logic [WIDTH-1:0] d, input logic cb);
    bit do_push, do_pop;
    bus.req          = r;
    bus.parallel_in  = d;
    bus.channel_busy = cb;
    do_push = r && (exp_q.size() < CAP);
    do_pop  = (exp_q.size() > 0) && !cb;
    if (exp_q.size() > 0 && cb && exp_stall < (1 << STALL_W) - 1) exp_stall++;
    @(posedge clk);
    if (do_pop)  void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(d);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag, input logic r);
    reset            = 1'b0;
    bus.req          = r;
    bus.parallel_in  = 32'hDEAD_BEEF;
    bus.channel_busy = 1'b0;
    @(posedge clk);
    exp_q.delete();
    exp_stall = 0;
    #1;
    check_outputs(tag);
    chk({tag, ".item_zero"}, bus.item_out, '0);
    reset = 1'b1;
  endtask

  initial begin
    reset            = 1'b0;
    bus.req          = 1'b0;
    bus.parallel_in  = '0;
    bus.channel_busy = 1'b0;

    do_reset("rst0", 1'b1);
    do_reset("rst1", 1'b0);

    // single flit
    cycle("single.push", 1'b1, 32'hA5A5_0001, 1'b0);
    chk("single.lat_valid", WIDTH'(bus.valid), 32'd1);
    cycle("single.drain", 1'b0, '0, 1'b0);
    cycle("single.idle", 1'b0, '0, 1'b0);

    // fill with back-pressure: 1..5 accepted, 6 dropped
    for (int i = 1; i <= 6; i++) cycle("fill.push", 1'b1, WIDTH'(i), 1'b1);
    chk("fill.level5", WIDTH'(level), 32'd5);
    chk("fill.busy", WIDTH'(bus.tx_busy), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      chk("fill.order", bus.item_out, WIDTH'(i));
      cycle("fill.drain", 1'b0, '0, 1'b0);
    end
    chk("fill.empty", WIDTH'(bus.valid), 32'd0);

    // full and pop in the same cycle: req dropped, level becomes DEPTH
    for (int i = 0; i < CAP; i++) cycle("fullpop.fill", 1'b1, 32'h100 + WIDTH'(i), 1'b1);
    cycle("fullpop.edge", 1'b1, 32'h1FF, 1'b0);
    chk("fullpop.level", WIDTH'(level), WIDTH'(DEPTH));
    for (int i = 0; i < CAP; i++) cycle("fullpop.drain", 1'b0, '0, 1'b0);

    // streaming
    for (int i = 0; i < 100; i++) begin
      cycle("stream", 1'b1, 32'h5000_0000 + WIDTH'(i), 1'b0);
      chk("stream.level_le1", WIDTH'(level <= 1), 32'd1);
    end
    cycle("stream.tail", 1'b0, '0, 1'b0);

    // intermittent back-pressure, push every other cycle
    for (int i = 0; i < 40; i++) begin
      cycle("toggle", (i % 2) == 0, 32'h7700_0000 + WIDTH'(i / 2), (i % 2) == 0);
      chk("toggle.no_busy", WIDTH'(bus.tx_busy), 32'd0);
    end
    for (int i = 0; i < 4; i++) cycle("toggle.drain", 1'b0, '0, 1'b0);

    // reset mid-operation with 3 flits held
    for (int i = 0; i < 3; i++) cycle("midrst.fill", 1'b1, 32'hC0 + WIDTH'(i), 1'b1);
    do_reset("midrst", 1'b1);
    cycle("midrst.push7", 1'b1, 32'h7, 1'b0);
    cycle("midrst.alone", 1'b0, '0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), $urandom,
            $urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < CAP + 1; i++) cycle("rand.drain", 1'b0, '0, 1'b0);

`ifdef PAR_TX_STALL_CNT_EN
    do_reset("stall.rst", 1'b0);
    cycle("stall.push", 1'b1, 32'h1234, 1'b1);
    for (int i = 0; i < 20; i++) cycle("stall.hold", 1'b0, '0, 1'b1);
    chk("stall.sat", WIDTH'(stall_cnt), 32'd15);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // hard time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/par_tx_buf.md
# par_tx_buf

Buffered, parametrised parallel flit transmitter for the router output ports. It accepts flits from the router core on a `req`/`tx_busy` handshake and stores them in a FIFO. It presents them to the link through a registered output stage that holds each flit until the link is not `channel_busy`. This decouples router switching from link back-pressure.

## Interface
Parameters:
- `WIDTH`, 32: flit width in bits (header + payload + address); instantiations pass `HDR_SZ+PL_SZ+ADDR_SZ`.
- `DEPTH`, 4: FIFO entries, excluding the output register; power of two, ≥2.
- `LVL_W`, 3: width of `level`; must satisfy 2^LVL_W > DEPTH+1.
- `STALL_W`, 16: width of `stall_cnt` (only with `PAR_TX_STALL_CNT_EN`).
- `port`, "unknown": port name string, used for debug only.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `req` in 1: producer offers the flit on `parallel_in` this cycle.
- `parallel_in` in WIDTH: flit from the router core.
- `tx_busy` out 1: buffer full; `req` is ignored while high.
- `channel_busy` in 1: link cannot take a flit this cycle.
- `item_out` out WIDTH: flit presented to the link (registered).
- `valid` out 1: `item_out` holds a flit (registered).
- `level` out LVL_W: flits held, including the output register; range 0..DEPTH+1.
- `stall_cnt` out STALL_W: only with `PAR_TX_STALL_CNT_EN`.

## Operation
- Storage is a circular FIFO of DEPTH entries (`wr_ptr`/`rd_ptr`, natural wrap at DEPTH) plus an output register (`item_out`, `valid`). Total capacity is DEPTH+1.
- **Push:** `req && !tx_busy`. `tx_busy` is derived from registered state only (`level == DEPTH+1`). A pop in the same cycle does not unblock a push.
- **Pop (transfer):** `valid && !channel_busy`. The flit on `item_out` is consumed at that edge.
- **Output register load priority, per edge:**
  - The output register is free if `!valid` or a pop occurs this cycle.
  - If the output register is free and the FIFO is non-empty, load the FIFO head and advance `rd_ptr`.
  - Else, if the output register is free, the FIFO is empty and a push occurs, load `parallel_in` directly (bypass; the FIFO is untouched).
  - Else, a push writes the FIFO at `wr_ptr`.
  - `valid` is 1 after the edge iff a flit was loaded, or the register held a flit that was not popped.
- FIFO order is strict; flits leave in acceptance order.
- `level` next value = level + push − pop.
- While `valid && channel_busy`, `item_out` and `valid` hold stable.
- `item_out` is not cleared on pop; it is meaningless while `valid = 0`.
- **Reset (`reset == 0` at an edge):** `valid = 0`, `item_out = 0`, `level = 0`, pointers 0, `tx_busy = 0`, `stall_cnt = 0`. Any stored flits are discarded, including mid-transfer. `req` in a reset cycle is ignored.

## Timing
- **Latency:** with the buffer empty, a push at edge N gives `valid = 1` with that flit after edge N.
- **Throughput:** with `channel_busy = 0`, one flit per cycle, sustained indefinitely.
- **Full:** after DEPTH+1 pushes with no pops, `tx_busy = 1` in the next cycle. The first pop clears `tx_busy` one cycle later.
- **Boundary cases:**
  - Full and pop in the same cycle: `req` is dropped and `level` becomes DEPTH.
  - Empty and push in the same cycle as a pop of the last flit: bypass load; `valid` stays 1.

## Configuration
- `PAR_TX_STALL_CNT_EN` defined:
  - Adds the `stall_cnt` output.
  - Increments by 1 each cycle with `valid && channel_busy`.
  - Saturates at 2^STALL_W−1; never wraps.
  - Cleared only by reset.
- `PAR_TX_STALL_CNT_EN` undefined: the port and counter logic are absent. All other behaviour is identical.

## Test plan
- **Single flit:** reset, then `req` = 1 for one cycle with `parallel_in` = 0xA5A5_0001 and `channel_busy` = 0 → `valid` = 1 and `item_out` = 0xA5A5_0001 for exactly one cycle, starting one cycle after the push; `level` goes 1 → 0.
- **Fill:** DEPTH = 4, `channel_busy` = 1, push values 1..6 back-to-back → values 1..5 are accepted, `tx_busy` = 1 after the 5th, `level` = 5, value 6 is dropped. Release `channel_busy` → output order 1, 2, 3, 4, 5, one per cycle.
- **Streaming:** `channel_busy` = 0, 100 consecutive pushes → 100 consecutive `valid` cycles, in order, with `level` ≤ 1 throughout.
- **Intermittent back-pressure:** `channel_busy` toggles every cycle during a 20-flit stream → `item_out` is stable across busy cycles, no loss or duplication, `tx_busy` never asserts.
- **Reset mid-operation:** assert reset while holding 3 flits with `valid` = 1 → next cycle `valid` = 0, `level` = 0, `tx_busy` = 0; a subsequent push of 0x7 emerges alone.
- **Stall counter** (with `PAR_TX_STALL_CNT_EN`, `STALL_W` = 4): one flit held with `channel_busy` = 1 for 20 cycles → `stall_cnt` reaches 15 and stays at 15.
